// File: rtl/sparc_exu_ecl_divseq.sv
// Divide iteration sequencer: walks LOAD -> ITER (32/64 steps) -> optional FIX -> DONE,
// holding the result until writeback grants it. Includes the scan flop used for state.

module dff_s #(
    parameter int SIZE = 1
) (
    input  logic [SIZE-1:0] din,
    input  logic            clk,
    output logic [SIZE-1:0] q,
    input  logic            se,
    input  logic [SIZE-1:0] si,
    output logic [SIZE-1:0] so
);
    // Scan chain is stitched by the flow; functionally this is a plain D flop.
    logic unused_scan;
    assign unused_scan = &{1'b0, se, si};

    always_ff @(posedge clk) begin
        q <= din;
    end

    assign so = q;
endmodule

module sparc_exu_ecl_divseq #(
    parameter int CNT_W = 6,
    parameter int TID_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             se,
    input  logic             div_req,
    input  logic [TID_W-1:0] div_tid,
    input  logic             div_64,
    input  logic             div_sign,
    input  logic             div_kill,
    input  logic             wb_ack,
    output logic             div_ack,
    output logic             div_busy,
    output logic             div_load,
    output logic             div_step,
    output logic             div_last,
    output logic             div_fix,
    output logic             div_done,
    output logic [TID_W-1:0] div_done_tid,
    output logic [CNT_W-1:0] div_cnt
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       state_q;
    logic [2:0]       unused_state_so;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [TID_W-1:0] tid_q;
    logic             mode64_q;
    logic             sign_q;
    logic             last_iter;
    logic             accept;

    dff_s #(.SIZE(3)) state_reg (
        .din (state_nxt),
        .clk (clk),
        .q   (state_q),
        .se  (se),
        .si  (3'b000),
        .so  (unused_state_so)
    );

    assign state = state_t'(state_q);

    assign accept    = (state == IDLE) & div_req & ~div_kill & ~reset;
    assign last_iter = (state == ITER) &
                       (mode64_q ? (cnt == CNT_W'(63)) : (cnt == CNT_W'(31)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = div_kill ? IDLE : ITER;
            end
            ITER: begin
                // Kill takes priority over completing the final step.
                if (div_kill) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last_iter) begin
                    state_nxt = sign_q ? FIX : DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FIX: begin
                if (div_kill) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Result is committed here, so kill no longer applies.
                if (wb_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (reset) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            tid_q    <= '0;
            mode64_q <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (accept) begin
                tid_q    <= div_tid;
                mode64_q <= div_64;
                sign_q   <= div_sign;
            end
        end
    end

    assign div_ack      = accept;
    assign div_busy     = (state != IDLE);
    assign div_load     = (state == LOAD);
    assign div_step     = (state == ITER);
    assign div_last     = last_iter;
    assign div_fix      = (state == FIX);
    assign div_done     = (state == DONE);
    assign div_done_tid = tid_q;
    assign div_cnt      = cnt;
endmodule

// File: tb/tb_sparc_exu_ecl_divseq.sv
// Bench for the divide sequencer: an age-based operation model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.

module tb_sparc_exu_ecl_divseq;
    logic       clk = 1'b0;
    logic       reset, se, div_req, div_64, div_sign, div_kill, wb_ack;
    logic [1:0] div_tid;
    logic       div_ack, div_busy, div_load, div_step, div_last, div_fix, div_done;
    logic [1:0] div_done_tid;
    logic [5:0] div_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    sparc_exu_ecl_divseq #(.CNT_W(6), .TID_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .se           (se),
        .div_req      (div_req),
        .div_tid      (div_tid),
        .div_64       (div_64),
        .div_sign     (div_sign),
        .div_kill     (div_kill),
        .wb_ack       (wb_ack),
        .div_ack      (div_ack),
        .div_busy     (div_busy),
        .div_load     (div_load),
        .div_step     (div_step),
        .div_last     (div_last),
        .div_fix      (div_fix),
        .div_done     (div_done),
        .div_done_tid (div_done_tid),
        .div_cnt      (div_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation is described by its age in cycles since acceptance.
    bit         m_act = 0;
    int         m_age = 0;
    int         m_n   = 32;
    bit         m_sgn = 0;
    logic [1:0] m_tid = 2'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 0;
            m_tid = 2'd0;
        end else if (!m_act) begin
            if (div_req && !div_kill) begin
                m_act = 1;
                m_age = 1;
                m_n   = div_64 ? 64 : 32;
                m_sgn = div_sign;
                m_tid = div_tid;
            end
        end else if (m_age >= m_n + 2 + int'(m_sgn)) begin
            if (wb_ack) m_act = 0;
        end else if (div_kill) begin
            m_act = 0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit e_ack  = !m_act && div_req && !div_kill && !reset;
            automatic bit e_load = m_act && m_age == 1;
            automatic bit e_step = m_act && m_age >= 2 && m_age <= m_n + 1;
            automatic bit e_last = e_step && m_age == m_n + 1;
            automatic bit e_fix  = m_act && m_sgn && m_age == m_n + 2;
            automatic bit e_done = m_act && m_age >= m_n + 2 + int'(m_sgn);
            automatic int e_cnt  = e_step ? m_age - 2 : ((e_fix || e_done) ? m_n - 1 : 0);
            chk("ack",  div_ack,  e_ack);
            chk("busy", div_busy, m_act);
            chk("load", div_load, e_load);
            chk("step", div_step, e_step);
            chk("last", div_last, e_last);
            chk("fix",  div_fix,  e_fix);
            chk("done", div_done, e_done);
            chk("tid",  div_done_tid, m_tid);
            chk("cnt",  div_cnt, e_cnt);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Caller is just after a rising edge in IDLE; this cycle becomes T.
    task automatic run_op(input bit m64, input bit sgn, input logic [1:0] tid);
        automatic int n = m64 ? 64 : 32;
        automatic int steps = 0;
        automatic int dones = 1;
        div_req = 1; div_tid = tid; div_64 = m64; div_sign = sgn;
        @(negedge clk); chk("op_ack_T", div_ack, 1);
        next_cycle(); div_req = 0;
        @(negedge clk); chk("op_load_T1", div_load, 1);
        for (int k = 2; k <= n + 1; k++) begin
            next_cycle();
            @(negedge clk);
            steps += int'(div_step);
            if (k == n + 1) begin
                chk("op_last", div_last, 1);
                chk("op_last_cnt", div_cnt, n - 1);
            end
        end
        chk("op_steps", steps, n);
        if (sgn) begin
            next_cycle();
            @(negedge clk);
            chk("op_fix", div_fix, 1);
            chk("op_fix_nodone", div_done, 0);
        end
        next_cycle();
        @(negedge clk);
        chk("op_done_first", div_done, 1);
        chk("op_done_tid", div_done_tid, tid);
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            if (i == 5) wb_ack = 1;
            @(negedge clk);
            dones += int'(div_done);
        end
        chk("op_done_cycles", dones, 6);
        next_cycle(); wb_ack = 0;
        @(negedge clk);
        chk("op_after_ack_done", div_done, 0);
        chk("op_after_ack_busy", div_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; se = 0; div_req = 0; div_tid = 0; div_64 = 0;
        div_sign = 0; div_kill = 0; wb_ack = 0;
        @(posedge clk); #1; chk_en = 1;
        repeat (2) next_cycle();
        reset = 0;
        @(negedge clk);
        chk("rst_busy", div_busy, 0);
        chk("rst_cnt", div_cnt, 0);
        chk("rst_tid", div_done_tid, 0);
        repeat (3) next_cycle();

        run_op(1'b0, 1'b0, 2'd2);
        next_cycle();
        run_op(1'b1, 1'b1, 2'd1);
        next_cycle();

        // Kill coinciding with the final step of a signed op.
        div_req = 1; div_tid = 2'd3; div_64 = 0; div_sign = 1;
        next_cycle(); div_req = 0;
        repeat (32) next_cycle();
        div_kill = 1;
        @(negedge clk); chk("kill_at_last", div_last, 1);
        next_cycle(); div_kill = 0;
        @(negedge clk);
        chk("kill_busy", div_busy, 0);
        chk("kill_fix", div_fix, 0);
        chk("kill_done", div_done, 0);

        // Kill together with a request in IDLE blocks acceptance.
        next_cycle(); div_req = 1; div_kill = 1;
        @(negedge clk); chk("idle_kill_ack", div_ack, 0);
        next_cycle(); div_req = 0; div_kill = 0;
        @(negedge clk); chk("idle_kill_busy", div_busy, 0);

        // Reset in the middle of iteration.
        next_cycle(); div_req = 1; div_64 = 1; div_sign = 0; div_tid = 2'd1;
        next_cycle(); div_req = 0;
        repeat (11) next_cycle();
        @(negedge clk); chk("mid_cnt10", div_cnt, 10);
        #1 reset = 1;
        next_cycle(); reset = 0;
        @(negedge clk);
        chk("mid_rst_busy", div_busy, 0);
        chk("mid_rst_cnt", div_cnt, 0);
        chk("mid_rst_tid", div_done_tid, 0);

        // Back-to-back with request held and writeback always granted.
        next_cycle();
        div_req = 1; wb_ack = 1;
        repeat (300) begin
            div_tid = 2'($urandom_range(0, 3));
            div_64 = ($urandom_range(0, 3) == 0);
            div_sign = $urandom_range(0, 1);
            next_cycle();
        end
        div_req = 0; wb_ack = 0;
        repeat (80) next_cycle();

        // Random traffic, including stray kill/wb_ack and occasional reset.
        repeat (3000) begin
            div_req  = ($urandom_range(0, 3) != 0);
            div_kill = ($urandom_range(0, 47) == 0);
            wb_ack   = ($urandom_range(0, 2) == 0);
            div_tid  = 2'($urandom_range(0, 3));
            div_64   = ($urandom_range(0, 3) == 0);
            div_sign = $urandom_range(0, 1);
            reset    = ($urandom_range(0, 999) == 0);
            se       = $urandom_range(0, 1);
            next_cycle();
        end
        div_req = 0; div_kill = 0; wb_ack = 0; reset = 0; se = 0;
        repeat (5) next_cycle();
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sparc_exu_ecl_divseq.md
# sparc_exu_ecl_divseq

Iteration sequencer for the EXU divider datapath. It accepts one divide request at a time from the ECL issue logic and steps a 6-bit iteration counter through 32 or 64 divide iterations. For signed operations it adds one sign-correction cycle, then holds the result valid until the writeback grant. Everything runs in the `clk` domain beside the divider flops, and all state resets synchronously.

## Interface
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W ≥ 64.
- `TID_W`, 2, thread-id width.

- `clk`  in  1  core clock; all flops are rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `se`  in  1  scan enable; passed to `dff_s` instances; no functional effect.
- `div_req`  in  1  divide request from issue, level.
- `div_tid`  in  TID_W  thread id of the request.
- `div_64`  in  1  1 = 64 iterations, 0 = 32 iterations.
- `div_sign`  in  1  1 = signed op; adds the FIX cycle.
- `div_kill`  in  1  flush; aborts the operation in flight.
- `wb_ack`  in  1  writeback grant for the completed result.
- `div_ack`  out  1  request accepted this cycle.
- `div_busy`  out  1  sequencer not in IDLE.
- `div_load`  out  1  load divider operand registers.
- `div_step`  out  1  perform one divide iteration.
- `div_last`  out  1  current step is the final iteration.
- `div_fix`  out  1  sign-correction cycle.
- `div_done`  out  1  result valid; held until `wb_ack`.
- `div_done_tid`  out  TID_W  thread id of the active or completed op.
- `div_cnt`  out  CNT_W  iteration index.

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE. The state register is a `dff_s`.
- Outputs are Moore-decoded from the state, except `div_ack`:
  - `div_load` = LOAD.
  - `div_step` = ITER.
  - `div_fix` = FIX.
  - `div_done` = DONE.
  - `div_busy` = any state other than IDLE.
- `div_ack` = IDLE & `div_req` & ~`div_kill` & ~`reset` (combinational).
- On `div_ack`:
  - latch `div_tid`, `div_64` and `div_sign`;
  - next state is LOAD.
- IDLE with `div_req` & `div_kill`: request not accepted; stay in IDLE.
- LOAD: lasts one cycle; `div_cnt` clears to 0; next state is ITER.
- ITER:
  - `div_last` = (`div_cnt` == 31 & ~mode64) | (`div_cnt` == 63 & mode64).
  - `div_cnt` increments every ITER cycle except the last, so it reads 0..N-1 across the iterations.
  - After the last step, next state is FIX if signed, otherwise DONE.
- FIX: lasts one cycle; next state is DONE; `div_cnt` holds at N-1.
- DONE:
  - `div_done` stays high; `div_cnt` holds.
  - On `wb_ack`, next state is IDLE and `div_cnt` clears to 0.
  - A new request is not accepted in the same cycle as `wb_ack`; `div_ack` fires only in IDLE.
- `wb_ack` in any state other than DONE is ignored.
- `div_kill` in LOAD, ITER or FIX:
  - next state is IDLE and `div_cnt` clears to 0;
  - no `div_done` is produced;
  - kill wins over a simultaneous last step.
- `div_kill` in DONE is ignored; the result is already committed. In IDLE it only blocks acceptance.
- `div_done_tid` holds the latched tid from acceptance until the next acceptance.
- `div_cnt` never wraps in normal operation; maximum value is 63. Increment is modulo 2^CNT_W.

## Timing
- Reset (sampled high at a rising edge):
  - state is IDLE; `div_cnt` = 0; `div_done_tid` = 0; latched mode and sign = 0.
  - All outputs are 0 in the following cycle.
  - Reset mid-operation abandons the op, same as kill but with no exception for DONE.
- Request accepted in cycle T (`div_ack`=1):
  - LOAD in T+1;
  - ITER from T+2 through T+N+1, with `div_last` in T+N+1;
  - if signed, FIX in T+N+2;
  - `div_done` first high in T+N+2 (unsigned) or T+N+3 (signed).
- 32-bit unsigned: `div_done` at T+34. 64-bit signed: `div_done` at T+67.
- `wb_ack` at cycle D while `div_done` is high: `div_done`=0 and state IDLE at D+1. Earliest next `div_ack` is D+1.
- `div_kill` at cycle K in LOAD/ITER/FIX: IDLE at K+1, with `div_step`, `div_fix` and `div_busy` all 0.

## Test plan
- Reset, then idle: all outputs 0, `div_cnt`=0. Assert `reset` during ITER at `div_cnt`=10 → IDLE and `div_cnt`=0 next cycle.
- 32-bit unsigned request at T with tid=2:
  - `div_ack`@T, `div_load`@T+1;
  - 32 `div_step` cycles; `div_last`@T+33 with `div_cnt`=31;
  - `div_done`@T+34 with `div_done_tid`=2.
  - Delay `wb_ack` 5 cycles → `div_done` held for 6 cycles, then IDLE.
- 64-bit signed request: `div_last`@T+65 with `div_cnt`=63, `div_fix`@T+66, `div_done`@T+67.
- `div_kill` in the same cycle as `div_last` → no FIX, no `div_done`, IDLE next cycle. `div_kill` with `div_req` in IDLE → no `div_ack`.
- `div_req` held high continuously with `wb_ack` tied 1:
  - back-to-back ops; each `div_ack` exactly 1 cycle after the previous DONE;
  - `div_done_tid` updates to the new tid on each acceptance.
- Random `wb_ack` and `div_kill` outside their valid states → no state change, counter unaffected.
